// File: rtl/ide_arb.sv
// Two-port arbiter sharing one ide register-access engine; grant 1 cycle after request, one guard cycle between owners.
// Non-owner strobes are stalled (level-held), never dropped; the owner may lock across accesses, bounded by an idle timeout.
module ide_arb #(
  parameter logic [15:0] IDLE_TIMEOUT = 16'd4096
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        rq0_lock,
  input  logic        rq0_ata_rd,
  input  logic        rq0_ata_wr,
  input  logic [4:0]  rq0_ata_addr,
  input  logic [15:0] rq0_ata_in,
  output logic [15:0] rq0_ata_out,
  output logic        rq0_ata_done,
  output logic        rq0_grant,

  input  logic        rq1_lock,
  input  logic        rq1_ata_rd,
  input  logic        rq1_ata_wr,
  input  logic [4:0]  rq1_ata_addr,
  input  logic [15:0] rq1_ata_in,
  output logic [15:0] rq1_ata_out,
  output logic        rq1_ata_done,
  output logic        rq1_grant,

  output logic        ata_rd,
  output logic        ata_wr,
  output logic [4:0]  ata_addr,
  output logic [15:0] ata_in,
  input  logic [15:0] ata_out,
  input  logic        ata_done,

  output logic        timeout_err,
  output logic        proto_err
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

  state_t      state;
  logic        rr;        // requester that wins the next tie
  logic [15:0] idle_cnt;

  logic        req0, req1;
  logic        own0, own1;
  logic        own_rd, own_wr, own_lock;
  logic [4:0]  own_addr;
  logic [15:0] own_in;
  logic        idle_lock;
  logic        release_own;
  logic [15:0] cnt_inc;
  logic        tmo_hit;

  assign req0 = rq0_ata_rd | rq0_ata_wr | rq0_lock;
  assign req1 = rq1_ata_rd | rq1_ata_wr | rq1_lock;
  assign own0 = (state == OWN0);
  assign own1 = (state == OWN1);

  always_comb begin
    own_rd   = 1'b0;
    own_wr   = 1'b0;
    own_lock = 1'b0;
    own_addr = 5'd0;
    own_in   = 16'd0;
    if (own0) begin
      own_rd   = rq0_ata_rd;
      own_wr   = rq0_ata_wr;
      own_lock = rq0_lock;
      own_addr = rq0_ata_addr;
      own_in   = rq0_ata_in;
    end else if (own1) begin
      own_rd   = rq1_ata_rd;
      own_wr   = rq1_ata_wr;
      own_lock = rq1_lock;
      own_addr = rq1_ata_addr;
      own_in   = rq1_ata_in;
    end
  end

  // A simultaneous rd+wr is resolved as a write so the engine never sees both strobes.
  assign ata_rd   = own_rd & ~own_wr;
  assign ata_wr   = own_wr;
  assign ata_addr = own_addr;
  assign ata_in   = own_in;

  assign rq0_ata_done = own0 & ata_done;
  assign rq1_ata_done = own1 & ata_done;
  assign rq0_ata_out  = own0 ? ata_out : 16'd0;
  assign rq1_ata_out  = own1 ? ata_out : 16'd0;

  assign idle_lock   = own_lock & ~own_rd & ~own_wr;
  assign release_own = (ata_done & ~own_lock) | (~own_rd & ~own_wr & ~own_lock);
  assign cnt_inc     = (&idle_cnt) ? idle_cnt : idle_cnt + 16'd1;
  assign tmo_hit     = (IDLE_TIMEOUT != 16'd0) && idle_lock && (cnt_inc == IDLE_TIMEOUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr          <= 1'b0;
      idle_cnt    <= 16'd0;
      rq0_grant   <= 1'b0;
      rq1_grant   <= 1'b0;
      timeout_err <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          idle_cnt <= 16'd0;
          if (req0 && (!req1 || !rr)) begin
            state     <= OWN0;
            rq0_grant <= 1'b1;
            rr        <= 1'b1;
          end else if (req1) begin
            state     <= OWN1;
            rq1_grant <= 1'b1;
            rr        <= 1'b0;
          end
        end
        OWN0, OWN1: begin
          if (own_rd && own_wr)
            proto_err <= 1'b1;
          if (release_own || tmo_hit) begin
            state       <= GAP;
            rq0_grant   <= 1'b0;
            rq1_grant   <= 1'b0;
            idle_cnt    <= 16'd0;
            timeout_err <= tmo_hit;
          end else if (own_rd || own_wr) begin
            idle_cnt <= 16'd0;
          end else if (own_lock) begin
            idle_cnt <= cnt_inc;
          end
        end
        GAP: begin
          state    <= IDLE;
          idle_cnt <= 16'd0;
        end
        default: begin
          state     <= IDLE;
          rq0_grant <= 1'b0;
          rq1_grant <= 1'b0;
          idle_cnt  <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ide_arb.sv
// Bench for ide_arb: directed scenarios plus random traffic, every cycle compared against a rule-level reference model.
module tb_ide_arb;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  lk = '0, rd = '0, wr = '0;
  logic [4:0]  ad [2];
  logic [15:0] di [2];
  logic [15:0] rq0_ata_out, rq1_ata_out;
  logic        rq0_ata_done, rq1_ata_done, rq0_grant, rq1_grant;
  logic        ata_rd, ata_wr;
  logic [4:0]  ata_addr;
  logic [15:0] ata_in;
  logic [15:0] ata_out = 16'd0;
  logic        ata_done = 1'b0;
  logic        timeout_err, proto_err;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the engine (-1 none), guard cycle, tie winner, idle-lock cycles, flags.
  int m_own = -1, n_own;
  bit m_gap = 0,  n_gap;
  int m_pref = 0, n_pref;
  int m_idle = 0, n_idle;
  bit m_tmo = 0,  n_tmo;
  bit m_perr = 0, n_perr;

  always #5 clk = ~clk;

  ide_arb #(.IDLE_TIMEOUT(16'd16)) dut (
    .clk(clk), .reset_n(reset_n),
    .rq0_lock(lk[0]), .rq0_ata_rd(rd[0]), .rq0_ata_wr(wr[0]), .rq0_ata_addr(ad[0]),
    .rq0_ata_in(di[0]), .rq0_ata_out(rq0_ata_out), .rq0_ata_done(rq0_ata_done), .rq0_grant(rq0_grant),
    .rq1_lock(lk[1]), .rq1_ata_rd(rd[1]), .rq1_ata_wr(wr[1]), .rq1_ata_addr(ad[1]),
    .rq1_ata_in(di[1]), .rq1_ata_out(rq1_ata_out), .rq1_ata_done(rq1_ata_done), .rq1_grant(rq1_grant),
    .ata_rd(ata_rd), .ata_wr(ata_wr), .ata_addr(ata_addr), .ata_in(ata_in),
    .ata_out(ata_out), .ata_done(ata_done),
    .timeout_err(timeout_err), .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_gap = 0; m_pref = 0; m_idle = 0; m_tmo = 0; m_perr = 0;
  endtask

  task automatic check_outputs();
    logic        e_rd, e_wr;
    logic [4:0]  e_ad;
    logic [15:0] e_in;
    e_rd = 1'b0; e_wr = 1'b0; e_ad = 5'd0; e_in = 16'd0;
    if (m_own >= 0) begin
      e_wr = wr[m_own];
      e_rd = rd[m_own] & ~wr[m_own];
      e_ad = ad[m_own];
      e_in = di[m_own];
    end
    chk("ata_rd", ata_rd, e_rd);
    chk("ata_wr", ata_wr, e_wr);
    chk("ata_addr", ata_addr, e_ad);
    chk("ata_in", ata_in, e_in);
    chk("rq0_grant", rq0_grant, m_own == 0);
    chk("rq1_grant", rq1_grant, m_own == 1);
    chk("rq0_done", rq0_ata_done, (m_own == 0) ? ata_done : 1'b0);
    chk("rq1_done", rq1_ata_done, (m_own == 1) ? ata_done : 1'b0);
    chk("rq0_out", rq0_ata_out, (m_own == 0) ? ata_out : 16'd0);
    chk("rq1_out", rq1_ata_out, (m_own == 1) ? ata_out : 16'd0);
    chk("timeout_err", timeout_err, m_tmo);
    chk("proto_err", proto_err, m_perr);
  endtask

  task automatic model_step();
    int  o, w;
    bit  r0, r1;
    n_own = m_own; n_gap = m_gap; n_pref = m_pref; n_idle = m_idle; n_tmo = 0; n_perr = m_perr;
    if (!reset_n) begin
      n_own = -1; n_gap = 0; n_pref = 0; n_idle = 0; n_perr = 0;
    end else if (m_gap) begin
      n_gap = 0;
    end else if (m_own < 0) begin
      r0 = rd[0] | wr[0] | lk[0];
      r1 = rd[1] | wr[1] | lk[1];
      w = (r0 && r1) ? m_pref : r0 ? 0 : r1 ? 1 : -1;
      n_idle = 0;
      if (w >= 0) begin
        n_own  = w;
        n_pref = 1 - w;
      end
    end else begin
      o = m_own;
      if (rd[o] && wr[o]) n_perr = 1;
      if ((ata_done && !lk[o]) || (!rd[o] && !wr[o] && !lk[o])) begin
        n_own = -1; n_gap = 1; n_idle = 0;
      end else if (rd[o] || wr[o]) begin
        n_idle = 0;
      end else begin
        n_idle = m_idle + 1;
        if (n_idle >= TMO) begin
          n_own = -1; n_gap = 1; n_idle = 0; n_tmo = 1;
        end
      end
    end
  endtask

  // One clock: compare mid-cycle, then advance the model past the rising edge.
  task automatic cyc();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
    m_own = n_own; m_gap = n_gap; m_pref = n_pref; m_idle = n_idle; m_tmo = n_tmo; m_perr = n_perr;
  endtask

  initial begin
    int held, fired, pulses, seen_g0;
    ad[0] = 5'd0; ad[1] = 5'd0; di[0] = 16'd0; di[1] = 16'd0;
    model_reset();

    // Reset state
    cyc(); cyc();
    chk("reset_grant0", rq0_grant, 1'b0);
    chk("reset_proto", proto_err, 1'b0);
    reset_n = 1'b1;
    cyc();

    // Tie after reset: rq0 first, then rq1 (rq0 re-requests immediately), then rq0 again
    rd[0] = 1'b1; ad[0] = 5'h17; rd[1] = 1'b1; ad[1] = 5'h03;
    cyc();
    chk("tie_first", {rq1_grant, rq0_grant}, 2'b01);
    cyc();
    ata_done = 1'b1; ata_out = 16'h1234;
    cyc();
    ata_done = 1'b0;
    cyc(); cyc();
    chk("tie_repeat", {rq1_grant, rq0_grant}, 2'b10);
    ata_done = 1'b1;
    cyc();
    ata_done = 1'b0; rd[1] = 1'b0;
    cyc(); cyc();
    chk("tie_third", {rq1_grant, rq0_grant}, 2'b01);
    ata_done = 1'b1;
    cyc();
    ata_done = 1'b0; rd[0] = 1'b0;
    cyc(); cyc();

    // Single uncontended read
    rd[0] = 1'b1; ad[0] = 5'b10111;
    cyc();
    chk("single_grant", rq0_grant, 1'b1);
    chk("single_rd", ata_rd, 1'b1);
    chk("single_addr", ata_addr, 5'h17);
    cyc(); cyc();
    ata_done = 1'b1; ata_out = 16'h0050;
    #1;
    chk("single_out", rq0_ata_out, 16'h0050);
    chk("single_done", rq0_ata_done, 1'b1);
    cyc();
    rd[0] = 1'b0; ata_done = 1'b0; ata_out = 16'd0;
    chk("single_gap", rq0_grant, 1'b0);
    cyc();
    chk("single_idle", ata_rd, 1'b0);
    cyc();

    // Lock: rq1 holds over 8 accesses while rq0 keeps requesting
    lk[1] = 1'b1;
    cyc();
    chk("lock_grant1", rq1_grant, 1'b1);
    rd[0] = 1'b1; ad[0] = 5'h11;
    seen_g0 = 0;
    for (int i = 0; i < 8; i++) begin
      wr[1] = i[0]; rd[1] = ~i[0]; ad[1] = 5'h08 + 5'(i); di[1] = 16'($urandom);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        cyc();
        if (rq0_grant) seen_g0++;
        chk("lock_addr_not_rq0", ata_addr != 5'h11, 1'b1);
      end
      ata_done = 1'b1; ata_out = 16'($urandom);
      cyc();
      ata_done = 1'b0; rd[1] = 1'b0; wr[1] = 1'b0;
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        cyc();
        if (rq0_grant) seen_g0++;
      end
    end
    chk("lock_no_grant0", seen_g0, 0);
    lk[1] = 1'b0;
    cyc();
    chk("lock_gap", {rq1_grant, rq0_grant}, 2'b00);
    cyc(); cyc();
    chk("lock_handover_gap_plus_grant", rq0_grant, 1'b1);
    ata_done = 1'b1;
    cyc();
    ata_done = 1'b0; rd[0] = 1'b0;
    cyc(); cyc();

    // Idle lock timeout
    lk[0] = 1'b1;
    cyc();
    held = 0; fired = 0;
    for (int k = 0; k < 40 && fired == 0; k++) begin
      if (rq0_grant) held++;
      cyc();
      if (timeout_err) fired = 1;
    end
    chk("tmo_fired", fired, 1);
    chk("tmo_held_cycles", held, TMO);
    chk("tmo_released", rq0_grant, 1'b0);
    lk[0] = 1'b0;
    cyc();
    chk("tmo_pulse_once", timeout_err, 1'b0);
    cyc();

    // Outstanding read under lock never times out
    lk[0] = 1'b1; rd[0] = 1'b1;
    cyc();
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (timeout_err) pulses++;
    end
    chk("tmo_mid_access", pulses, 0);
    chk("tmo_still_owner", rq0_grant, 1'b1);
    ata_done = 1'b1;
    cyc();
    ata_done = 1'b0; rd[0] = 1'b0; lk[0] = 1'b0;
    cyc(); cyc(); cyc();

    // rd and wr together
    rd[1] = 1'b1; wr[1] = 1'b1; ad[1] = 5'h1f; di[1] = 16'hbeef;
    cyc();
    chk("proto_rd", ata_rd, 1'b0);
    chk("proto_wr", ata_wr, 1'b1);
    cyc();
    chk("proto_set", proto_err, 1'b1);
    ata_done = 1'b1;
    cyc();
    ata_done = 1'b0; rd[1] = 1'b0; wr[1] = 1'b0;
    cyc(); cyc();
    chk("proto_sticky", proto_err, 1'b1);

    // Asynchronous reset during an rq1 write
    wr[1] = 1'b1; ad[1] = 5'h03;
    cyc(); cyc();
    chk("rst_pre_wr", ata_wr, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_wr", ata_wr, 1'b0);
    chk("rst_async_grant", rq1_grant, 1'b0);
    model_reset();
    wr[1] = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    chk("rst_idle", {rq1_grant, rq0_grant}, 2'b00);
    chk("rst_proto_clr", proto_err, 1'b0);

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      for (int r = 0; r < 2; r++) begin
        lk[r] = ($urandom_range(0, 3) == 0);
        rd[r] = ($urandom_range(0, 2) == 0);
        wr[r] = ($urandom_range(0, 5) == 0);
        ad[r] = 5'($urandom);
        di[r] = 16'($urandom);
      end
      ata_done = ($urandom_range(0, 3) == 0);
      ata_out  = 16'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
